// File: rtl/updown_pkg.sv
// +----------------------------------------------------------------------------+
// | updown_pkg : mode encoding and parameter legality helper for the counter.   |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package updown_pkg;

  typedef enum logic [1:0] {
    UD_HOLD = 2'b00,
    UD_UP   = 2'b01,
    UD_DOWN = 2'b10,
    UD_LOAD = 2'b11
  } ud_mode_t;

  function automatic bit params_legal(
    input int unsigned     width,
    input longint unsigned min_val,
    input longint unsigned max_val,
    input longint unsigned step,
    input longint unsigned reset_val
  );
    longint unsigned lim;
    if (width < 2 || width > 32) return 1'b0;
    lim = (64'd1 << width) - 64'd1;
    return (min_val < max_val) && (max_val <= lim) &&
           (step >= 64'd1) && (step <= max_val - min_val) &&
           (reset_val >= min_val) && (reset_val <= max_val);
  endfunction

endpackage

`default_nettype wire

// File: rtl/updown_counter_param.sv
// +----------------------------------------------------------------------------+
// | updown_counter_param : ranged up/down/load counter, wrap or saturate.       |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module updown_counter_param
  import updown_pkg::*;
#(
  parameter int             WIDTH     = 4,
  parameter logic [WIDTH-1:0] MIN_VAL   = '0,
  parameter logic [WIDTH-1:0] MAX_VAL   = '1,
  parameter logic [WIDTH-1:0] STEP      = WIDTH'(1),
  parameter bit             WRAP      = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = MIN_VAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       up_down,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic             Y,
  output logic             ovf,
  output logic             unf,
  output logic             load_err
);

  if (!params_legal(WIDTH, 64'(MIN_VAL), 64'(MAX_VAL), 64'(STEP), 64'(RESET_VAL))) begin : g_param_check
    $error("updown_counter_param: illegal parameter combination");
  end

  localparam logic [WIDTH:0] MIN_E  = {1'b0, MIN_VAL};
  localparam logic [WIDTH:0] MAX_E  = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] STEP_E = {1'b0, STEP};
  localparam logic [WIDTH:0] ONE_E  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] state_q, state_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             load_err_q, load_err_d;

  ud_mode_t       w_mode;
  logic [WIDTH:0] w_st;
  logic [WIDTH:0] w_room_up;
  logic [WIDTH:0] w_room_dn;

  assign w_mode    = ud_mode_t'(up_down);
  assign w_st      = {1'b0, state_q};
  // Headroom to each bound; state is always in range so neither can go negative.
  assign w_room_up = MAX_E - w_st;
  assign w_room_dn = w_st - MIN_E;

  always_comb begin
    state_d    = state_q;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      state_d = RESET_VAL;
    end else if (en) begin
      case (w_mode)
        UD_HOLD: state_d = state_q;
        UD_UP: begin
          if (w_room_up >= STEP_E) begin
            state_d = WIDTH'(w_st + STEP_E);
          end else begin
            ovf_d   = 1'b1;
            state_d = WRAP ? WIDTH'(MIN_E + (STEP_E - w_room_up - ONE_E)) : MAX_VAL;
          end
        end
        UD_DOWN: begin
          if (w_room_dn >= STEP_E) begin
            state_d = WIDTH'(w_st - STEP_E);
          end else begin
            unf_d   = 1'b1;
            state_d = WRAP ? WIDTH'(MAX_E - (STEP_E - w_room_dn - ONE_E)) : MIN_VAL;
          end
        end
        UD_LOAD: begin
          if (load_val > MAX_VAL) begin
            state_d    = MAX_VAL;
            load_err_d = 1'b1;
          end else if (load_val < MIN_VAL) begin
            state_d    = MIN_VAL;
            load_err_d = 1'b1;
          end else begin
            state_d = load_val;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RESET_VAL;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      load_err_q <= load_err_d;
    end
  end

  assign state    = state_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign load_err = load_err_q;
  assign Y        = ((w_mode == UD_UP)   && (state_q == MAX_VAL)) ||
                    ((w_mode == UD_DOWN) && (state_q == MIN_VAL));

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_param.sv
// +----------------------------------------------------------------------------+
// | tb_updown_counter_param : five counter configurations vs. integer model.    |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_updown_counter_param;
  import updown_pkg::*;

  localparam int N = 5;
  localparam int C_MIN  [N] = '{0,  0, 0, 0,  2};
  localparam int C_MAX  [N] = '{15, 9, 9, 15, 12};
  localparam int C_STEP [N] = '{1,  1, 3, 1,  2};
  localparam int C_WRAP [N] = '{1,  1, 1, 0,  0};
  localparam int C_RST  [N] = '{0,  0, 0, 0,  7};

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       clr;
  logic [1:0] up_down;
  logic [3:0] load_val;
  logic [3:0] st   [N];
  logic       y    [N];
  logic       ovf  [N];
  logic       unf  [N];
  logic       lerr [N];

  int m_st   [N];
  bit m_ovf  [N];
  bit m_unf  [N];
  bit m_lerr [N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    updown_counter_param #(
      .WIDTH    (4),
      .MIN_VAL  (4'(C_MIN[g])),
      .MAX_VAL  (4'(C_MAX[g])),
      .STEP     (4'(C_STEP[g])),
      .WRAP     (C_WRAP[g] != 0),
      .RESET_VAL(4'(C_RST[g]))
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .clr     (clr),
      .up_down (up_down),
      .load_val(load_val),
      .state   (st[g]),
      .Y       (y[g]),
      .ovf     (ovf[g]),
      .unf     (unf[g]),
      .load_err(lerr[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i]   = C_RST[i];
      m_ovf[i]  = 1'b0;
      m_unf[i]  = 1'b0;
      m_lerr[i] = 1'b0;
    end
  endtask

  // Range arithmetic on plain integers: overshoot past a bound re-enters from the other end.
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      int nxt;
      m_ovf[i]  = 1'b0;
      m_unf[i]  = 1'b0;
      m_lerr[i] = 1'b0;
      if (clr) begin
        m_st[i] = C_RST[i];
      end else if (en) begin
        if (up_down == UD_UP) begin
          nxt = m_st[i] + C_STEP[i];
          if (nxt > C_MAX[i]) begin
            m_ovf[i] = 1'b1;
            m_st[i]  = (C_WRAP[i] != 0) ? C_MIN[i] + (nxt - C_MAX[i] - 1) : C_MAX[i];
          end else begin
            m_st[i] = nxt;
          end
        end else if (up_down == UD_DOWN) begin
          nxt = m_st[i] - C_STEP[i];
          if (nxt < C_MIN[i]) begin
            m_unf[i] = 1'b1;
            m_st[i]  = (C_WRAP[i] != 0) ? C_MAX[i] - (C_MIN[i] - nxt - 1) : C_MIN[i];
          end else begin
            m_st[i] = nxt;
          end
        end else if (up_down == UD_LOAD) begin
          if (int'(load_val) > C_MAX[i]) begin
            m_st[i] = C_MAX[i];  m_lerr[i] = 1'b1;
          end else if (int'(load_val) < C_MIN[i]) begin
            m_st[i] = C_MIN[i];  m_lerr[i] = 1'b1;
          end else begin
            m_st[i] = int'(load_val);
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      bit ey;
      ey = ((up_down == UD_UP) && (m_st[i] == C_MAX[i])) ||
           ((up_down == UD_DOWN) && (m_st[i] == C_MIN[i]));
      chk($sformatf("%s[%0d].state", tag, i), 32'(st[i]), 32'(m_st[i]));
      chk($sformatf("%s[%0d].Y", tag, i), 32'(y[i]), 32'(ey));
      chk($sformatf("%s[%0d].ovf", tag, i), 32'(ovf[i]), 32'(m_ovf[i]));
      chk($sformatf("%s[%0d].unf", tag, i), 32'(unf[i]), 32'(m_unf[i]));
      chk($sformatf("%s[%0d].load_err", tag, i), 32'(lerr[i]), 32'(m_lerr[i]));
    end
  endtask

  task automatic step(input bit c, input bit e, input ud_mode_t m, input logic [3:0] lv,
                      input string tag);
    clr      = c;
    en       = e;
    up_down  = m;
    load_val = lv;
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2 reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; up_down = UD_HOLD; load_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;
    step(0, 1, UD_HOLD, 4'd0, "hold");

    step(0, 1, UD_LOAD, 4'd8, "ld8");
    step(0, 1, UD_UP, 4'd0, "up9");
    chk("wrap_st9", 32'(st[1]), 32'd9);
    chk("wrap_y9", 32'(y[1]), 32'd1);
    chk("stepwrap_up_st", 32'(st[2]), 32'd1);
    chk("stepwrap_up_ovf", 32'(ovf[2]), 32'd1);
    step(0, 1, UD_UP, 4'd0, "upwrap");
    chk("wrap_st0", 32'(st[1]), 32'd0);
    chk("wrap_ovf", 32'(ovf[1]), 32'd1);
    step(0, 1, UD_DOWN, 4'd0, "dnwrap");
    chk("wrap_dn_st", 32'(st[1]), 32'd9);
    chk("wrap_dn_unf", 32'(unf[1]), 32'd1);
    chk("wrap_ovf_gone", 32'(ovf[1]), 32'd0);
    step(0, 1, UD_DOWN, 4'd0, "dn2");
    chk("stepwrap_dn_st", 32'(st[2]), 32'd8);
    chk("stepwrap_dn_unf", 32'(unf[2]), 32'd1);

    step(0, 1, UD_LOAD, 4'd15, "ld15");
    for (int k = 0; k < 3; k++) begin
      step(0, 1, UD_UP, 4'd0, "sat_up");
      chk("sat_up_st", 32'(st[3]), 32'd15);
      chk("sat_up_ovf", 32'(ovf[3]), 32'd1);
    end
    async_reset("arst_pulse");
    step(0, 1, UD_LOAD, 4'd0, "ld0");
    step(0, 1, UD_DOWN, 4'd0, "sat_dn");
    chk("sat_dn_st", 32'(st[3]), 32'd0);
    chk("sat_dn_unf", 32'(unf[3]), 32'd1);

    step(0, 1, UD_LOAD, 4'd5, "ld5");
    chk("clamp_in_st", 32'(st[4]), 32'd5);
    chk("clamp_in_err", 32'(lerr[4]), 32'd0);
    step(0, 1, UD_LOAD, 4'd14, "ld14");
    chk("clamp_hi_st", 32'(st[4]), 32'd12);
    chk("clamp_hi_err", 32'(lerr[4]), 32'd1);
    step(0, 1, UD_LOAD, 4'd0, "ld0b");
    chk("clamp_lo_st", 32'(st[4]), 32'd2);
    chk("clamp_lo_err", 32'(lerr[4]), 32'd1);

    step(0, 1, UD_LOAD, 4'd6, "ld6");
    step(0, 1, UD_UP, 4'd0, "up7");
    chk("pre_arst_st", 32'(st[0]), 32'd7);
    async_reset("arst7");
    chk("arst7_st", 32'(st[0]), 32'd0);
    chk("arst7_ovf", 32'(ovf[0]), 32'd0);

    step(0, 1, UD_LOAD, 4'd7, "ld7");
    for (int k = 0; k < 4; k++) begin
      step(0, 0, UD_UP, 4'd0, "en_off");
      chk("en_off_st", 32'(st[0]), 32'd7);
      chk("en_off_ovf", 32'(ovf[0]), 32'd0);
    end
    step(0, 1, UD_UP, 4'd0, "en_on");
    chk("en_on_st", 32'(st[0]), 32'd8);

    step(1, 1, UD_UP, 4'd0, "clr");
    chk("clr_st0", 32'(st[0]), 32'd0);
    chk("clr_st4", 32'(st[4]), 32'd7);

    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           ud_mode_t'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), "rnd");
      if ($urandom_range(0, 63) == 0) async_reset("rnd_arst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised successor to the 4-bit up/down counter. Configurable width, counting range [MIN_VAL..MAX_VAL], step size and wrap/saturate policy. Adds an explicit load mode, count enable, synchronous clear and registered overflow/underflow pulses. Used as a generic tick/index counter in datapath and timing blocks.

Parameters:
WIDTH, 4, counter width in bits (2..32)
MIN_VAL, 0, lowest legal count
MAX_VAL, 2**WIDTH-1, highest legal count; must satisfy MIN_VAL < MAX_VAL <= 2**WIDTH-1
STEP, 1, increment/decrement per enabled cycle; 1 <= STEP <= MAX_VAL-MIN_VAL
WRAP, 1, 1 = modular wrap within range; 0 = saturate at the bounds
RESET_VAL, MIN_VAL, count value after reset; must lie within [MIN_VAL..MAX_VAL]

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  count enable; when 0, the mode is ignored and the count holds
clr  in  1  synchronous clear to RESET_VAL; overrides en and up_down
up_down  in  2  mode: 00 HOLD, 01 UP, 10 DOWN, 11 LOAD
load_val  in  WIDTH  data loaded in LOAD mode
state  out  WIDTH  current count (registered)
Y  out  1  terminal count (combinational): state==MAX_VAL in UP mode, state==MIN_VAL in DOWN mode, else 0
ovf  out  1  one-cycle registered pulse: an UP step crossed MAX_VAL
unf  out  1  one-cycle registered pulse: a DOWN step crossed MIN_VAL
load_err  out  1  one-cycle registered pulse: load_val was outside the range and was clamped

Behaviour:
- Reset (reset=0, asynchronous): state=RESET_VAL; ovf=unf=load_err=0. Release takes effect on the next rising edge of clk.
- Priority per edge: clr > en=0 > mode. All registered outputs update on the same edge; latency is 1 cycle.
- clr=1: state<=RESET_VAL; pulse outputs <=0.
- en=0: state holds; pulse outputs <=0.
- HOLD: state holds; pulses <=0.
- UP:
  - If MAX_VAL-state >= STEP: state<=state+STEP; ovf<=0.
  - Otherwise ovf<=1, and:
    - WRAP=1: state<=MIN_VAL+(STEP-(MAX_VAL-state)-1).
    - WRAP=0: state<=MAX_VAL.
  - ovf also asserts when already saturated at MAX_VAL.
- DOWN: mirror image of UP.
  - If state-MIN_VAL >= STEP: state<=state-STEP.
  - Otherwise unf<=1, and:
    - WRAP=1: state<=MAX_VAL-(STEP-(state-MIN_VAL)-1).
    - WRAP=0: state<=MIN_VAL.
- LOAD:
  - load_val>MAX_VAL: state<=MAX_VAL, load_err<=1.
  - load_val<MIN_VAL: state<=MIN_VAL, load_err<=1.
  - Otherwise state<=load_val, load_err<=0.
  - ovf=unf=0.
- Arithmetic: compute in WIDTH+1 bits so no intermediate overflow. state never leaves [MIN_VAL..MAX_VAL].
- Pulses are exclusive: at most one of ovf/unf/load_err is high in a cycle.
- Y is combinational from state and up_down; it is not gated by en.
- Reset asserted mid-count: immediate return to RESET_VAL, and any pulse in flight is cleared.
- Parameter legality is checked with elaboration-time assertions.

Decomposition:
- Shared package updown_pkg:
  - typedef enum logic [1:0] ud_mode_t {UD_HOLD, UD_UP, UD_DOWN, UD_LOAD}.
  - Parameter-check helper function.
- No sub-module. Next-state logic is one always_comb block; registers are one always_ff block with asynchronous negedge reset.

Test Plan:
- Reset/clear: default params; reset=0 mid-count at state=7 -> state=0 immediately; ovf=0. Later clr=1 with up_down=UP -> state=0 next edge.
- Wrap up: WIDTH=4, MAX_VAL=9, STEP=1, WRAP=1; UP from 8 -> 9 (Y=1), then 0 with ovf=1 for one cycle; DOWN from 0 -> 9 with unf=1.
- Step wrap: STEP=3, MIN 0, MAX 9; UP from 8 -> 1 with ovf=1; DOWN from 1 -> 8 with unf=1.
- Saturate: WRAP=0, default range; UP at 15 for 3 cycles -> state stays 15, ovf=1 each cycle; DOWN at 0 -> stays 0, unf=1.
- Load/clamp: MIN 2, MAX 12; LOAD 5 -> 5, load_err=0; LOAD 14 -> 12, load_err=1; LOAD 0 -> 2, load_err=1.
- Enable gating: en=0 with UP for 4 cycles -> state unchanged, no pulses; en=1 -> counting resumes from the held value.
